bus_router: RTL and testbench
=============================

// Module: bus_router
// PURPOSE
//  Parametrised successor address router for the OTTER bus fabric. Sits between the
//  CPU-side bus primary and N_TGT target slaves (memory, system/MMIO, ...). Selects a
//  target from the address region field. Runs each access as a registered transaction
//  with a target ack handshake, a timeout watchdog, and error responses for unmapped
//  or misaligned accesses.
// PARAMETERS
//  N_TGT       2                    number of target ports (1..8)
//  ADDR_W      32                   address width
//  DATA_W      32                   data width
//  RGN_W       4                    region field = addr[ADDR_W-1 -: RGN_W]
//  RGN_LO      {4'h4,4'h0}          packed N_TGT*RGN_W; lowest region of target i
//  RGN_HI      {4'h5,4'h3}          packed N_TGT*RGN_W; highest region of target i (inclusive)
//  TIMEOUT     255                  max cycles t_req is held without ack (>=1)
// PORTS
//  clk       in   1              clock, rising edge
//  rst_n     in   1              asynchronous active-low reset
//  m_req     in   1              primary request (rd or wr); sampled only in IDLE
//  m_wr      in   1              1 = write, 0 = read
//  m_size    in   2              0 = byte, 1 = half, 2 = word (3 = illegal)
//  m_addr    in   ADDR_W         byte address
//  m_wdata   in   DATA_W         write data
//  m_busy    out  1              transaction in progress (state != IDLE)
//  m_ready   out  1              1-cycle response strobe
//  m_rdata   out  DATA_W         read data, valid with m_ready
//  m_error   out  1              error, valid with m_ready
//  t_req     out  N_TGT          one-hot request to selected target
//  t_wr      out  1              latched m_wr (shared)
//  t_size    out  2              latched m_size (shared)
//  t_addr    out  ADDR_W         latched full address (shared)
//  t_wdata   out  DATA_W         latched write data (shared)
//  t_ack     in   N_TGT          target completion
//  t_rdata   in   N_TGT*DATA_W   target read data, slice i valid with t_ack[i]
//  t_error   in   N_TGT          target error, valid with t_ack[i]
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs, latches and counter 0; t_req drops immediately
//    (asynchronous), including mid-transaction. Outstanding transaction is discarded.
//  - FSM IDLE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly on decode fault.
//  - IDLE: on m_req, latch wr/size/addr/wdata and decode.
//    * Hit: target i hits if RGN_LO[i] <= region <= RGN_HI[i]; lowest i wins on overlap.
//    * Fault: no hit; or size==3; or size==1 with addr[0]; or size==2 with addr[1:0]!=0.
//    * On fault: -> RESP, m_error=1, m_rdata=0; no target sees t_req.
//  - WAIT: t_req[sel]=1 every cycle; counter starts at 0 and increments per cycle.
//    * t_ack[sel]=1: capture t_rdata[sel] and t_error[sel], drop t_req, -> RESP.
//    * No ack while counter==TIMEOUT-1: drop t_req, -> RESP with m_error=1, m_rdata=0.
//    * Ack on the final cycle beats timeout.
//    * t_ack of unselected targets ignored.
//  - RESP: m_ready=1 for exactly one cycle with registered m_rdata/m_error, then IDLE.
//    * m_rdata/m_error return to 0 when m_ready=0.
//  - m_req outside IDLE ignored; primary re-requests only after m_ready.
//  - Latency (req sampled at edge N): fault -> m_ready high in cycle N+1.
//    Ack in first WAIT cycle -> m_ready in N+2; each extra wait cycle adds 1.
//  - Back-to-back: m_req held through the m_ready cycle starts the next transaction
//    at the edge leaving RESP+IDLE, i.e. min 3-cycle issue interval.
//  - t_ack outside WAIT ignored; counter width = $clog2(TIMEOUT+1).
// TESTING
//  1. Read 0x0000_0010 word, tgt0 acks 1st WAIT cycle, rdata 0xDEADBEEF
//     -> t_req=2'b01 one cycle; m_ready at N+2, m_rdata=0xDEADBEEF, m_error=0.
//  2. Write 0x5000_0004 word, wdata 0x12345678, tgt1 acks after 3 cycles
//     -> t_req=2'b10 held 4 cycles, t_wr=1, t_wdata=0x12345678; m_ready at N+5.
//  3. Read 0x8000_0000 (unmapped) and word read 0x0000_0002 (misaligned)
//     -> m_ready at N+1, m_error=1, m_rdata=0, t_req never asserted.
//  4. Tgt0 never acks, TIMEOUT=4 -> t_req high exactly 4 cycles; m_ready with m_error=1.
//     Repeat with ack on 4th cycle -> m_error=t_error, data captured.
//  5. rst_n low while in WAIT -> t_req, m_busy 0 with no clock edge.
//     After release, idle with no spurious m_ready; next request completes normally.
//  6. Tgt1 asserts t_ack and t_error stray during tgt0 WAIT and in IDLE -> no effect.
//     Tgt0 ack with t_error=1 -> m_error=1.

Source files
------------

// File: rtl/bus_router_if.sv
// ----------------------------------------------------------------------------
// bus_router_if
// Purpose : Bundles the CPU-side primary bus and the shared target-side bus
//           of the OTTER address router into one interface.
// Signals : m_*  primary request/response (CPU side)
//           t_*  target request/response (slave side, t_req one-hot)
// Modports: slave  - view of the router itself
//           master - view of the environment (CPU + targets) driving the router
// ----------------------------------------------------------------------------
interface bus_router_if #(
    parameter int N_TGT  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Primary side
    logic                    m_req;
    logic                    m_wr;
    logic [1:0]              m_size;
    logic [ADDR_W-1:0]       m_addr;
    logic [DATA_W-1:0]       m_wdata;
    logic                    m_busy;
    logic                    m_ready;
    logic [DATA_W-1:0]       m_rdata;
    logic                    m_error;

    // Target side
    logic [N_TGT-1:0]        t_req;
    logic                    t_wr;
    logic [1:0]              t_size;
    logic [ADDR_W-1:0]       t_addr;
    logic [DATA_W-1:0]       t_wdata;
    logic [N_TGT-1:0]        t_ack;
    logic [N_TGT*DATA_W-1:0] t_rdata;
    logic [N_TGT-1:0]        t_error;

    modport slave (
        input  m_req, m_wr, m_size, m_addr, m_wdata,
        output m_busy, m_ready, m_rdata, m_error,
        output t_req, t_wr, t_size, t_addr, t_wdata,
        input  t_ack, t_rdata, t_error
    );

    modport master (
        output m_req, m_wr, m_size, m_addr, m_wdata,
        input  m_busy, m_ready, m_rdata, m_error,
        input  t_req, t_wr, t_size, t_addr, t_wdata,
        output t_ack, t_rdata, t_error
    );
endinterface

// File: rtl/bus_router.sv
// ----------------------------------------------------------------------------
// bus_router
// Purpose : Address router between the CPU-side primary and N_TGT target
//           slaves. The target is selected from the top RGN_W address bits.
//           Each access runs as a registered transaction with a target ack
//           handshake, a timeout watchdog and error responses for unmapped
//           or misaligned accesses.
// Ports   : clk          clock, rising edge
//           rst_n        asynchronous active-low reset
//           io_bus       bus_router_if.slave (primary + target buses)
//           o_dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
// Handshake: the primary raises m_req with m_wr/m_size/m_addr/m_wdata stable;
// it is sampled only in IDLE, and the primary may re-request only after the
// single-cycle m_ready strobe (m_rdata/m_error valid only with m_ready, 0
// otherwise). Toward the targets, t_req[sel] stays high every WAIT cycle with
// the t_* command held stable; the selected target completes by raising
// t_ack[sel] for one cycle with its t_rdata slice and t_error valid. Acks from
// unselected targets, or outside WAIT, are ignored.
// ----------------------------------------------------------------------------
module bus_router #(
    parameter int                     N_TGT   = 2,
    parameter int                     ADDR_W  = 32,
    parameter int                     DATA_W  = 32,
    parameter int                     RGN_W   = 4,
    parameter logic [N_TGT*RGN_W-1:0] RGN_LO  = {4'h4, 4'h0},
    parameter logic [N_TGT*RGN_W-1:0] RGN_HI  = {4'h5, 4'h3},
    parameter int                     TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_router_if.slave        io_bus,
    output logic [1:0]         o_dbg_state
);
    localparam int SEL_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [SEL_W-1:0]    r_sel;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_wr;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_error;

    logic [RGN_W-1:0]    w_region;
    logic                w_dec_hit;
    logic [SEL_W-1:0]    w_dec_sel;
    logic                w_misalign;
    logic                w_fault;
    logic                w_ack;
    logic [DATA_W-1:0]   w_ack_rdata;
    logic                w_ack_error;
    logic                w_timeout;

    // ------------------------------------------------------------------
    // Address decode of the live primary request
    // ------------------------------------------------------------------
    assign w_region = io_bus.m_addr[ADDR_W-1 -: RGN_W];

    // Scan from the highest index down so the lowest matching target is
    // the last assignment and wins on overlapping regions.
    always_comb begin
        w_dec_hit = 1'b0;
        w_dec_sel = '0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if ((w_region >= RGN_LO[i*RGN_W +: RGN_W]) &&
                (w_region <= RGN_HI[i*RGN_W +: RGN_W])) begin
                w_dec_hit = 1'b1;
                w_dec_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        case (io_bus.m_size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = io_bus.m_addr[0];
            2'd2:    w_misalign = (io_bus.m_addr[1:0] != 2'b00);
            default: w_misalign = 1'b1;   // size 3 is illegal
        endcase
    end

    assign w_fault = !w_dec_hit || w_misalign;

    // ------------------------------------------------------------------
    // Response mux from the selected target only
    // ------------------------------------------------------------------
    always_comb begin
        w_ack       = 1'b0;
        w_ack_rdata = '0;
        w_ack_error = 1'b0;
        for (int i = 0; i < N_TGT; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_ack       = io_bus.t_ack[i];
                w_ack_rdata = io_bus.t_rdata[i*DATA_W +: DATA_W];
                w_ack_error = io_bus.t_error[i];
            end
        end
    end

    // Last permitted WAIT cycle; an ack in this same cycle still wins.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // FSM: state register + next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (io_bus.m_req) begin
                    w_next_state = w_fault ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_ack || w_timeout) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: command latch, wait counter, response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel   <= '0;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (io_bus.m_req) begin
                        r_wr    <= io_bus.m_wr;
                        r_size  <= io_bus.m_size;
                        r_addr  <= io_bus.m_addr;
                        r_wdata <= io_bus.m_wdata;
                        r_sel   <= w_dec_sel;
                        r_rdata <= '0;
                        // A decode fault goes straight to RESP carrying the error.
                        r_error <= w_fault;
                    end
                end
                S_WAIT: begin
                    if (w_ack) begin
                        r_rdata <= w_ack_rdata;
                        r_error <= w_ack_error;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_rdata <= '0;
                    r_error <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // t_req is decoded from state so an asynchronous reset drops it at once.
    always_comb begin
        io_bus.t_req = '0;
        if (r_state == S_WAIT) begin
            for (int i = 0; i < N_TGT; i++) begin
                io_bus.t_req[i] = (r_sel == SEL_W'(i));
            end
        end
    end

    assign io_bus.t_wr    = r_wr;
    assign io_bus.t_size  = r_size;
    assign io_bus.t_addr  = r_addr;
    assign io_bus.t_wdata = r_wdata;

    assign io_bus.m_busy  = (r_state != S_IDLE);
    assign io_bus.m_ready = (r_state == S_RESP);
    assign io_bus.m_rdata = (r_state == S_RESP) ? r_rdata : '0;
    assign io_bus.m_error = (r_state == S_RESP) ? r_error : 1'b0;

    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_bus_router.sv
// ----------------------------------------------------------------------------
// tb_bus_router
// Purpose : Self-checking bench for bus_router (N_TGT=2, TIMEOUT=4).
//           Vector table of single transactions with an inline target model,
//           plus hand sequences for reset mid-transaction and back-to-back
//           issue. Responses are checked through an expected-response queue.
// ----------------------------------------------------------------------------
module tb_bus_router;
    localparam int N_TGT   = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;
    localparam int NVEC    = 13;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // {m_error, m_rdata}
    logic [DATA_W:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          tgt;        // target that responds
        int          delay;      // WAIT cycle index of ack, -1 = never
        logic [31:0] rdata;
        logic        terr;
        logic        stray;      // other target raises ack/error all along
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_treq;
        int          exp_lat;    // cycles from request edge to m_ready
        int          exp_nreq;   // cycles with t_req asserted
    } vec_t;

    vec_t vecs[NVEC];

    bus_router_if #(.N_TGT(N_TGT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bus_router #(
        .N_TGT   (N_TGT),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RGN_W   (4),
        .RGN_LO  ({4'h4, 4'h0}),
        .RGN_HI  ({4'h5, 4'h3}),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .io_bus      (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.m_req   = 1'b0;
        bus.m_wr    = 1'b0;
        bus.m_size  = 2'd0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.t_ack   = '0;
        bus.t_error = '0;
        bus.t_rdata = '0;
    endtask

    task automatic pop_compare(input string name);
        logic [DATA_W:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check(name, {bus.m_error, bus.m_rdata}, e);
        end
    endtask

    // One transaction from the vector table with an inline target model.
    task automatic run_vec(input int idx);
        vec_t        v;
        logic [1:0]  tmask;
        logic [1:0]  smask;
        logic [1:0]  ack;
        logic [1:0]  terr;
        logic        done;
        logic        bad_treq;
        logic        spurious;
        int          nreq;
        int          lat;
        string       tag;

        v     = vecs[idx];
        tag   = $sformatf("v%0d", idx);
        tmask = 2'b01 << v.tgt;
        smask = v.stray ? (~tmask) : 2'b00;

        @(negedge clk);
        bus.t_rdata = '0;
        bus.t_rdata[v.tgt*DATA_W +: DATA_W]     = v.rdata;
        bus.t_rdata[(1-v.tgt)*DATA_W +: DATA_W] = 32'hBAD0_BAD0;
        bus.t_ack   = smask;
        bus.t_error = smask;

        // Stray acks while idle must not produce a response.
        if (v.stray) begin
            spurious = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (bus.m_ready || bus.m_busy) spurious = 1'b1;
            end
            check({tag, "_stray_idle"}, spurious, 1'b0);
        end

        exp_q.push_back({v.exp_err, v.exp_rdata});
        bus.m_req   = 1'b1;
        bus.m_wr    = v.wr;
        bus.m_size  = v.size;
        bus.m_addr  = v.addr;
        bus.m_wdata = v.wdata;

        @(posedge clk);
        done     = 1'b0;
        bad_treq = 1'b0;
        nreq     = 0;
        lat      = 0;
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            @(negedge clk);
            bus.m_req = 1'b0;
            if (bus.m_ready) begin
                done = 1'b1;
                lat  = cyc;
                check({tag, "_busy_resp"}, bus.m_busy, 1'b1);
                pop_compare({tag, "_resp"});
            end else if (bus.t_req != 2'b00) begin
                nreq++;
                if (bus.t_req != v.exp_treq) bad_treq = 1'b1;
                if (nreq == 1) begin
                    check({tag, "_t_cmd"}, {bus.t_wr, bus.t_size, bus.t_addr, bus.t_wdata},
                          {v.wr, v.size, v.addr, v.wdata});
                    check({tag, "_busy_wait"}, bus.m_busy, 1'b1);
                end
            end
            ack  = smask;
            terr = smask;
            if (((bus.t_req & tmask) != 2'b00) && (v.delay == nreq - 1)) begin
                ack  = ack | tmask;
                terr = v.terr ? (terr | tmask) : terr;
            end
            bus.t_ack   = ack;
            bus.t_error = terr;
        end

        if (!done) begin
            check({tag, "_resp_timeout"}, 64'd0, 64'd1);
            void'(exp_q.pop_front());
        end else begin
            check({tag, "_latency"}, lat, v.exp_lat);
        end
        check({tag, "_treq_cycles"}, nreq, v.exp_nreq);
        check({tag, "_treq_onehot"}, bad_treq, 1'b0);

        // Response strobe is exactly one cycle and data returns to 0.
        @(negedge clk);
        check({tag, "_after_resp"}, {bus.m_ready, bus.m_busy, bus.m_error, bus.m_rdata},
              {1'b0, 1'b0, 1'b0, 32'h0});
        idle_inputs();
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic spurious;
        int   pulses;
        int   first_pulse;
        int   last_pulse;
        logic bad_gap;

        //           wr    sz    addr          wdata         tg dl  rdata         te    st    eerr  erdata        etreq lat nreq
        vecs[0]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,        0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 2'b01, 2, 1};
        vecs[1]  = '{1'b1, 2'd2, 32'h5000_0004, 32'h1234_5678, 1, 3, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        2'b10, 5, 4};
        vecs[2]  = '{1'b0, 2'd2, 32'h8000_0000, 32'h0,        0, -1, 32'h0,       1'b0, 1'b0, 1'b1, 32'h0,        2'b00, 1, 0};
        vecs[3]  = '{1'b0, 2'd2, 32'h0000_0002, 32'h0,        0, -1, 32'h0,       1'b0, 1'b0, 1'b1, 32'h0,        2'b00, 1, 0};
        vecs[4]  = '{1'b0, 2'd2, 32'h3000_0000, 32'h0,        0, -1, 32'h5555_AAAA, 1'b0, 1'b0, 1'b1, 32'h0,      2'b01, 5, 4};
        vecs[5]  = '{1'b0, 2'd2, 32'h3000_000C, 32'h0,        0, 3, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 2'b01, 5, 4};
        vecs[6]  = '{1'b0, 2'd2, 32'h1000_0000, 32'h0,        0, 1, 32'h1111_2222, 1'b1, 1'b1, 1'b1, 32'h1111_2222, 2'b01, 3, 2};
        vecs[7]  = '{1'b0, 2'd1, 32'h4000_0001, 32'h0,        1, -1, 32'h0,       1'b0, 1'b0, 1'b1, 32'h0,        2'b00, 1, 0};
        vecs[8]  = '{1'b0, 2'd1, 32'h4000_0002, 32'h0,        1, 0, 32'h0000_A5A5, 1'b0, 1'b0, 1'b0, 32'h0000_A5A5, 2'b10, 2, 1};
        vecs[9]  = '{1'b0, 2'd0, 32'h5FFF_FFFF, 32'h0,        1, 2, 32'h0000_00C3, 1'b0, 1'b0, 1'b0, 32'h0000_00C3, 2'b10, 4, 3};
        vecs[10] = '{1'b0, 2'd3, 32'h0000_0000, 32'h0,        0, -1, 32'h0,       1'b0, 1'b0, 1'b1, 32'h0,        2'b00, 1, 0};
        vecs[11] = '{1'b0, 2'd2, 32'h6000_0000, 32'h0,        1, -1, 32'h0,       1'b0, 1'b0, 1'b1, 32'h0,        2'b00, 1, 0};
        vecs[12] = '{1'b1, 2'd0, 32'h0000_0003, 32'h0000_00AB, 0, 0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        2'b01, 2, 1};

        // Reset state
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_m", {bus.m_busy, bus.m_ready, bus.m_error, bus.m_rdata}, {1'b0, 1'b0, 1'b0, 32'h0});
        check("reset_t", {bus.t_req, bus.t_wr, bus.t_size, bus.t_addr, bus.t_wdata[15:0]},
              {2'b00, 1'b0, 2'd0, 32'h0, 16'h0});
        check("reset_state", dbg_state, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven transactions
        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // Reset asserted mid-WAIT: t_req and m_busy drop without a clock edge
        @(negedge clk);
        bus.m_req  = 1'b1;
        bus.m_size = 2'd2;
        bus.m_addr = 32'h2000_0000;
        @(posedge clk);
        @(negedge clk);
        bus.m_req = 1'b0;
        check("rst_pre_treq", bus.t_req, 2'b01);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_treq", bus.t_req, 2'b00);
        check("rst_async_busy", {bus.m_busy, dbg_state}, {1'b0, 2'd0});
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.m_ready || bus.m_busy) spurious = 1'b1;
        end
        check("rst_no_spurious", spurious, 1'b0);
        idle_inputs();
        run_vec(0);

        // Back-to-back: m_req held, target 0 acks in the first WAIT cycle
        @(negedge clk);
        bus.t_rdata = {32'hBAD0_BAD0, 32'hDEAD_BEEF};
        bus.m_req   = 1'b1;
        bus.m_size  = 2'd2;
        bus.m_addr  = 32'h0000_0040;
        @(posedge clk);
        pulses      = 0;
        first_pulse = 0;
        last_pulse  = 0;
        bad_gap     = 1'b0;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            if (bus.m_ready) begin
                exp_q.push_back({1'b0, 32'hDEAD_BEEF});
                pop_compare($sformatf("b2b_resp%0d", pulses));
                if (pulses == 0) first_pulse = cyc;
                else if (cyc - last_pulse != 3) bad_gap = 1'b1;
                last_pulse = cyc;
                pulses++;
            end
            bus.t_ack = {1'b0, bus.t_req[0]};
            if (cyc == 11) bus.m_req = 1'b0;
        end
        check("b2b_first", first_pulse, 2);
        check("b2b_pulses", pulses, 4);
        check("b2b_interval", bad_gap, 1'b0);
        @(negedge clk);
        bus.t_ack = '0;
        @(negedge clk);
        check("b2b_idle", {bus.m_busy, bus.m_ready}, 2'b00);

        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
